alu_req_driver: RTL and testbench

//  Initiator side of the 8-bit ALU interface: queues operation requests, drives A/B/select onto an ALU,

---
 rtl/alu_req_driver.sv | 174 +++++++++++++++++
 tb/tb_alu_req_driver.sv | 396 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_req_driver.sv
// Initiator for an 8-bit combinational ALU: command FIFO, settle window,
// qualified capture and a tagged valid/ready response with an op counter.
module alu_req_driver #(
  parameter int FIFO_DEPTH    = 4,
  parameter int SETTLE_CYCLES = 1,
  parameter int TAG_W         = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic [7:0]                    cmd_a,
  input  logic [7:0]                    cmd_b,
  input  logic [3:0]                    cmd_sel,
  input  logic [TAG_W-1:0]              cmd_tag,
  output logic [7:0]                    alu_a,
  output logic [7:0]                    alu_b,
  output logic [3:0]                    alu_sel,
  input  logic [7:0]                    alu_out,
  input  logic                          alu_carry,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [7:0]                    rsp_result,
  output logic                          rsp_carry,
  output logic                          rsp_zero,
  output logic                          rsp_div0,
  output logic [TAG_W-1:0]              rsp_tag,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic [15:0]                   ops_done
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CW-1:0] FULL  = CW'(FIFO_DEPTH);
  localparam logic [SW-1:0] SLAST = SW'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRIVE,
    S_RESP
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [7:0]       r_mem_a   [FIFO_DEPTH];
  logic [7:0]       r_mem_b   [FIFO_DEPTH];
  logic [3:0]       r_mem_sel [FIFO_DEPTH];
  logic [TAG_W-1:0] r_mem_tag [FIFO_DEPTH];

  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic [SW-1:0]    r_settle;
  logic [TAG_W-1:0] r_tag;
  logic [7:0]       r_alu_a;
  logic [7:0]       r_alu_b;
  logic [3:0]       r_alu_sel;
  logic [7:0]       r_result;
  logic             r_carry;
  logic             r_zero;
  logic             r_div0;
  logic [TAG_W-1:0] r_rsp_tag;
  logic [15:0]      r_ops_done;

  logic             w_push;
  logic             w_pop;
  logic             w_last;
  logic             w_rsp_hs;
  logic             w_div0;
  logic [7:0]       w_result;

  assign cmd_ready  = (r_count != FULL);
  assign w_push     = cmd_valid & cmd_ready;
  assign w_pop      = (r_state == S_IDLE) & (r_count != '0);
  assign w_last     = (r_state == S_DRIVE) & (r_settle == SLAST);
  assign w_rsp_hs   = (r_state == S_RESP) & rsp_ready;

  // Division by zero never trusts the ALU; result is saturated instead.
  assign w_div0     = (r_alu_sel == 4'b0011) & (r_alu_b == 8'h00);
  assign w_result   = w_div0 ? 8'hFF : alu_out;

  assign alu_a      = r_alu_a;
  assign alu_b      = r_alu_b;
  assign alu_sel    = r_alu_sel;
  assign rsp_valid  = (r_state == S_RESP);
  assign rsp_result = r_result;
  assign rsp_carry  = r_carry;
  assign rsp_zero   = r_zero;
  assign rsp_div0   = r_div0;
  assign rsp_tag    = r_rsp_tag;
  assign busy       = (r_state != S_IDLE) | (r_count != '0);
  assign fifo_count = r_count;
  assign ops_done   = r_ops_done;

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (w_pop)     w_next = S_DRIVE;
      S_DRIVE: if (w_last)    w_next = S_RESP;
      S_RESP:  if (rsp_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_a[r_wr_ptr]   <= cmd_a;
      r_mem_b[r_wr_ptr]   <= cmd_b;
      r_mem_sel[r_wr_ptr] <= cmd_sel;
      r_mem_tag[r_wr_ptr] <= cmd_tag;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (!w_push && w_pop) r_count <= r_count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_alu_a   <= '0;
      r_alu_b   <= '0;
      r_alu_sel <= '0;
      r_tag     <= '0;
      r_settle  <= '0;
    end else if (w_pop) begin
      r_alu_a   <= r_mem_a[r_rd_ptr];
      r_alu_b   <= r_mem_b[r_rd_ptr];
      r_alu_sel <= r_mem_sel[r_rd_ptr];
      r_tag     <= r_mem_tag[r_rd_ptr];
      r_settle  <= '0;
    end else if (r_state == S_DRIVE && !w_last) begin
      r_settle  <= r_settle + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_result  <= '0;
      r_carry   <= 1'b0;
      r_zero    <= 1'b0;
      r_div0    <= 1'b0;
      r_rsp_tag <= '0;
    end else if (w_last) begin
      r_result  <= w_result;
      r_carry   <= (r_alu_sel == 4'b0000) & alu_carry;
      r_zero    <= (w_result == 8'h00);
      r_div0    <= w_div0;
      r_rsp_tag <= r_tag;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n)        r_ops_done <= '0;
    else if (w_rsp_hs) r_ops_done <= r_ops_done + 16'd1;
  end

endmodule

// File: tb/tb_alu_req_driver.sv
// Bench for alu_req_driver: behavioural ALU, queue-based response model,
// directed scenarios plus randomized traffic.
module tb_alu_req_driver;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_a;
  logic [7:0] cmd_b;
  logic [3:0] cmd_sel;
  logic [3:0] cmd_tag;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [3:0] alu_sel;
  logic [7:0] alu_out;
  logic       alu_carry;
  logic [8:0] alu_sum;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_result;
  logic       rsp_carry;
  logic       rsp_zero;
  logic       rsp_div0;
  logic [3:0] rsp_tag;
  logic       busy;
  logic [2:0] fifo_count;
  logic [15:0] ops_done;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] res;
    logic       c;
    logic       z;
    logic       d;
    logic [3:0] tag;
  } exp_t;

  always #5 clk = ~clk;

  alu_req_driver #(
    .FIFO_DEPTH(4),
    .SETTLE_CYCLES(1),
    .TAG_W(4)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b),
    .cmd_sel(cmd_sel), .cmd_tag(cmd_tag),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .alu_out(alu_out), .alu_carry(alu_carry),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_carry(rsp_carry),
    .rsp_zero(rsp_zero), .rsp_div0(rsp_div0),
    .rsp_tag(rsp_tag), .busy(busy),
    .fifo_count(fifo_count), .ops_done(ops_done)
  );

  function automatic logic [7:0] alu_fn(
    input logic [7:0] a, input logic [7:0] b, input logic [3:0] s);
    logic [15:0] m;
    m = 16'(a) * 16'(b);
    case (s)
      4'd0:  return a + b;
      4'd1:  return a - b;
      4'd2:  return m[7:0];
      4'd3:  return (b == 0) ? 8'h5A : a / b;
      4'd4:  return a & b;
      4'd5:  return a | b;
      4'd6:  return a ^ b;
      4'd7:  return ~a;
      4'd8:  return a << 1;
      4'd9:  return a >> 1;
      4'd10: return a + 8'd1;
      4'd11: return a - 8'd1;
      4'd12: return ~(a & b);
      4'd13: return ~(a | b);
      4'd14: return (a < b) ? 8'd1 : 8'd0;
      default: return (a == b) ? 8'd1 : 8'd0;
    endcase
  endfunction

  always_comb begin
    alu_out   = alu_fn(alu_a, alu_b, alu_sel);
    alu_sum   = {1'b0, alu_a} + {1'b0, alu_b};
    alu_carry = alu_sum[8];
  end

  function automatic exp_t model(
    input logic [7:0] a, input logic [7:0] b,
    input logic [3:0] s, input logic [3:0] t);
    exp_t e;
    int   sum;
    sum   = int'(a) + int'(b);
    e.d   = (s == 4'd3) && (b == 8'd0);
    e.res = e.d ? 8'hFF : alu_fn(a, b, s);
    e.c   = (s == 4'd0) && (sum > 255);
    e.z   = (e.res == 8'd0);
    e.tag = t;
    return e;
  endfunction

  function automatic exp_t mk(
    input logic [7:0] r, input logic c, input logic z,
    input logic d, input logic [3:0] t);
    exp_t e;
    e.res = r; e.c = c; e.z = z; e.d = d; e.tag = t;
    return e;
  endfunction

  task automatic send(
    input logic [7:0] a, input logic [7:0] b,
    input logic [3:0] s, input logic [3:0] t);
    int n = 0;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_a = a; cmd_b = b; cmd_sel = s; cmd_tag = t;
    while (!cmd_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      checks++; errors++;
      $display("FAIL send_timeout: cmd_ready=%b want 1", cmd_ready);
    end
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic recv(input exp_t e, input string nm);
    int n = 0;
    @(negedge clk);
    rsp_ready = 1'b1;
    while (!rsp_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!rsp_valid) begin
      errors++;
      $display("FAIL %s: rsp_valid=0 after timeout, want 1", nm);
    end else if ({rsp_result, rsp_carry, rsp_zero, rsp_div0, rsp_tag}
                 !== {e.res, e.c, e.z, e.d, e.tag}) begin
      errors++;
      $display("FAIL %s: got r=%h c=%b z=%b d=%b t=%h want r=%h c=%b z=%b d=%b t=%h",
        nm, rsp_result, rsp_carry, rsp_zero, rsp_div0, rsp_tag,
        e.res, e.c, e.z, e.d, e.tag);
    end
    @(posedge clk);
    #1 rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b0;
    cmd_a = '0; cmd_b = '0; cmd_sel = '0; cmd_tag = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if ({rsp_valid, busy, fifo_count} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctl: v=%b busy=%b cnt=%0d want 0", rsp_valid, busy, fifo_count);
    end
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: got %b want 1", cmd_ready);
    end
    checks++;
    if (ops_done !== 16'd0) begin
      errors++;
      $display("FAIL reset_ops: got %h want 0", ops_done);
    end
    checks++;
    if ({alu_a, alu_b, alu_sel} !== 20'h0) begin
      errors++;
      $display("FAIL reset_alu: got %h %h %h want 0", alu_a, alu_b, alu_sel);
    end
    checks++;
    if ({rsp_result, rsp_carry, rsp_zero, rsp_div0, rsp_tag} !== 15'h0) begin
      errors++;
      $display("FAIL reset_rsp: got r=%h t=%h want 0", rsp_result, rsp_tag);
    end
  endtask

  task automatic test_latency();
    @(negedge clk);
    cmd_valid = 1'b1; cmd_a = 8'hF0; cmd_b = 8'h20;
    cmd_sel = 4'd0; cmd_tag = 4'd3;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0 || fifo_count !== 3'd1) begin
      errors++;
      $display("FAIL lat_e0: v=%b cnt=%0d want v=0 cnt=1", rsp_valid, fifo_count);
    end
    @(posedge clk);
    #1;
    checks++;
    if ({rsp_valid, fifo_count, busy} !== {1'b0, 3'd0, 1'b1} ||
        {alu_a, alu_b, alu_sel} !== {8'hF0, 8'h20, 4'h0}) begin
      errors++;
      $display("FAIL lat_e1: v=%b cnt=%0d busy=%b alu=%h/%h/%h want 0/0/1 F0/20/0",
        rsp_valid, fifo_count, busy, alu_a, alu_b, alu_sel);
    end
    @(posedge clk);
    #1;
    checks++;
    if ({rsp_valid, rsp_result, rsp_carry, rsp_zero, rsp_div0, rsp_tag}
        !== {1'b1, 8'h10, 1'b1, 1'b0, 1'b0, 4'd3}) begin
      errors++;
      $display("FAIL lat_e2: v=%b r=%h c=%b z=%b d=%b t=%h want 1 10 1 0 0 3",
        rsp_valid, rsp_result, rsp_carry, rsp_zero, rsp_div0, rsp_tag);
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0 || ops_done !== 16'd1) begin
      errors++;
      $display("FAIL lat_hs: v=%b ops=%0d want v=0 ops=1", rsp_valid, ops_done);
    end
  endtask

  task automatic test_ops();
    send(8'h05, 8'h05, 4'd1, 4'd1);
    recv(mk(8'h00, 1'b0, 1'b1, 1'b0, 4'd1), "sub_zero");
    send(8'hF0, 8'h20, 4'd1, 4'd2);
    recv(mk(8'hD0, 1'b0, 1'b0, 1'b0, 4'd2), "sub_nocarry");
    send(8'h40, 8'h00, 4'd3, 4'd4);
    recv(mk(8'hFF, 1'b0, 1'b0, 1'b1, 4'd4), "div_by_zero");
    send(8'h40, 8'h04, 4'd3, 4'd5);
    recv(mk(8'h10, 1'b0, 1'b0, 1'b0, 4'd5), "div_ok");
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({alu_a, alu_b, alu_sel} !== {8'h40, 8'h04, 4'd3}) begin
      errors++;
      $display("FAIL alu_hold: got %h/%h/%h want 40/04/3", alu_a, alu_b, alu_sel);
    end
  endtask

  task automatic test_backpressure();
    rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++)
      send(8'(i * 16 + 1), 8'(i), 4'd0, 4'(8 + i));
    checks++;
    if (cmd_ready !== 1'b0 || fifo_count !== 3'd4) begin
      errors++;
      $display("FAIL bp_full: rdy=%b cnt=%0d want 0/4", cmd_ready, fifo_count);
    end
    @(negedge clk);
    cmd_valid = 1'b1; cmd_tag = 4'hF;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    checks++;
    if (fifo_count !== 3'd4) begin
      errors++;
      $display("FAIL bp_nopush: cnt=%0d want 4", fifo_count);
    end
    for (int i = 0; i < 5; i++)
      recv(model(8'(i * 16 + 1), 8'(i), 4'd0, 4'(8 + i)), "bp_order");
  endtask

  task automatic test_reset_mid();
    int seen = 0;
    send(8'h11, 8'h22, 4'd4, 4'd1);
    while (!rsp_valid && seen < 20) begin
      @(posedge clk);
      #1 seen++;
    end
    send(8'h01, 8'h01, 4'd0, 4'd2);
    send(8'h02, 8'h02, 4'd0, 4'd3);
    send(8'h03, 8'h03, 4'd0, 4'd4);
    @(negedge clk);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (fifo_count !== 3'd2 || rsp_valid !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL rm_pre: cnt=%0d v=%b busy=%b want 2/0/1", fifo_count, rsp_valid, busy);
    end
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if ({rsp_valid, fifo_count, ops_done, busy} !== 21'h0) begin
      errors++;
      $display("FAIL rm_reset: v=%b cnt=%0d ops=%0d busy=%b want 0",
        rsp_valid, fifo_count, ops_done, busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    rsp_ready = 1'b0;
    checks++;
    if (seen != 0 || ops_done !== 16'd0) begin
      errors++;
      $display("FAIL rm_stray: rsp seen=%0d ops=%0d want 0/0", seen, ops_done);
    end
  endtask

  task automatic test_random();
    exp_t q[$];
    exp_t e;
    int   n_ok = 0;
    int   cyc  = 0;
    for (int i = 0; i < 400 || (q.size() != 0 && cyc < 600); i++) begin
      cyc = i;
      @(negedge clk);
      if (i < 400) begin
        cmd_valid = 1'($urandom_range(0, 1));
        cmd_a     = 8'($urandom);
        cmd_b     = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
        cmd_sel   = 4'($urandom);
        cmd_tag   = 4'($urandom);
        rsp_ready = ($urandom_range(0, 3) != 0);
      end else begin
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
      end
      #1;
      if (rsp_valid && rsp_ready) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL rnd_stray: tag=%h with empty model queue", rsp_tag);
        end else begin
          e = q.pop_front();
          n_ok++;
          if ({rsp_result, rsp_carry, rsp_zero, rsp_div0, rsp_tag}
              !== {e.res, e.c, e.z, e.d, e.tag}) begin
            errors++;
            $display("FAIL rnd_rsp: got r=%h c=%b z=%b d=%b t=%h want r=%h c=%b z=%b d=%b t=%h",
              rsp_result, rsp_carry, rsp_zero, rsp_div0, rsp_tag,
              e.res, e.c, e.z, e.d, e.tag);
          end
        end
      end
      if (cmd_valid && cmd_ready)
        q.push_back(model(cmd_a, cmd_b, cmd_sel, cmd_tag));
      @(posedge clk);
    end
    #1 rsp_ready = 1'b0;
    checks++;
    if (q.size() != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rnd_drain: left=%0d busy=%b want 0/0", q.size(), busy);
    end
    checks++;
    if (ops_done !== 16'(n_ok)) begin
      errors++;
      $display("FAIL rnd_ops: got %0d want %0d", ops_done, n_ok);
    end
  endtask

  task automatic test_wrap();
    @(negedge clk);
    force dut.r_ops_done = 16'hFFFF;
    @(negedge clk);
    release dut.r_ops_done;
    send(8'h80, 8'h80, 4'd0, 4'd7);
    recv(mk(8'h00, 1'b1, 1'b1, 1'b0, 4'd7), "wrap_rsp");
    checks++;
    if (ops_done !== 16'd0) begin
      errors++;
      $display("FAIL wrap_ops: got %h want 0000", ops_done);
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_ops();
    test_backpressure();
    test_reset_mid();
    test_random();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
